elevator_dispatcher: RTL
========================

# elevator_dispatcher

- Request-side front end for the elevator `Controller`.
- Collects floor calls into a pending mask and selects targets in SCAN order (serve in the current direction, then reverse).
- Drives the controller's `requested_floor`; uses its `y` and `wait_floor` outputs as arrival feedback.
- Holds each served floor for a programmable dwell time before the next target is issued.

## Interface
- `NUM_FLOORS`, 15: served floors 0..NUM_FLOORS-1; legal range 2..15 (the controller ignores requests ≥15).
- `DWELL_CYCLES`, 4: cycles the car is held at a served floor; legal range 1..255.
- `clk` input 1: rising-edge clock.
- `reset` input 1: reset is asynchronous and active-low.
- `call_valid` input 1: single-cycle call strobe.
- `call_floor` input 5: called floor, sampled when `call_valid`=1.
- `cur_floor` input 5: car position, from controller `y`.
- `at_floor` input 1: car stopped at `requested_floor`, from controller `wait_floor[0]`.
- `requested_floor` output 5: registered target to controller.
- `pending` output NUM_FLOORS: registered outstanding-call mask.
- `dir_up` output 1: registered direction; 1 = up.
- `dwell` output 1: high while holding at a served floor (door-open window).
- `busy` output 1: high in any state except IDLE.

## Operation
- **States:** IDLE, UP, DOWN, DWELL. 2-bit state register.
- **Call capture:**
  - `call_valid` with `call_floor` < NUM_FLOORS sets that `pending` bit the next cycle.
  - Out-of-range calls are dropped silently.
  - Duplicate calls are idempotent.
- **Arrival:** `at_floor`=1 and `cur_floor`==`requested_floor` while in UP/DOWN.
- **IDLE:**
  - `requested_floor`<=`cur_floor`.
  - If `pending[cur_floor]`: clear the bit and go to DWELL.
  - Else if any pending floor is above the car and (`dir_up`=1 or none is below): go to UP.
  - Else if any pending floor is below: go to DOWN.
- **UP:**
  - Each cycle, `requested_floor`<= lowest pending floor strictly above `cur_floor`, so a new nearer call retargets the car.
  - On arrival: clear that bit, go to DWELL.
  - If no pending floor is above (e.g. cancelled): go to IDLE.
- **DOWN:** mirror of UP, using the highest pending floor strictly below `cur_floor`.
- **DWELL:**
  - `requested_floor`<=`cur_floor`; counter loads DWELL_CYCLES-1 on entry and counts down.
  - A call to `cur_floor` during DWELL is absorbed (bit not set).
  - At count 0, with `dir_up`=1:
    - pending above → UP;
    - else pending below → DOWN and `dir_up`<=0;
    - else IDLE.
  - With `dir_up`=0 the same order applies, mirrored.
- **Direction:** `dir_up` updates only on entering UP (1) or DOWN (0).
- **Simultaneous events:**
  - A call to the floor being cleared in the same cycle is absorbed (clear wins).
  - Calls to other floors are never lost.
- **Reset mid-operation:** everything returns to reset values; outstanding calls are discarded.

## Timing
- **Reset values:**
  - state=IDLE, `pending`=0, `requested_floor`=0;
  - `dir_up`=1, `dwell`=0, `busy`=0, dwell counter=0.
- **Call-to-mask latency:** 1 cycle.
- **Mask-to-target latency:** 1 cycle; IDLE→UP/DOWN and the first `requested_floor` update happen on the same edge.
- **Arrival:** arrival cycle +1 gives state=DWELL, `dwell`=1.
  - `dwell` stays high exactly DWELL_CYCLES cycles.
  - The next target appears on the edge after the last dwell cycle.
- **Priority encoders:** combinational over `pending`, masked by `cur_floor`; no extra pipeline stage.
- All outputs are registered.

## Configuration
- Macro: `DISPATCH_CANCEL_EN`.
- **Defined:** adds ports `cancel_valid` (in 1) and `cancel_floor` (in 5).
  - A cancel clears that `pending` bit next cycle.
  - Cancel beats a same-cycle call to the same floor.
  - Cancelling the active target while in UP/DOWN retargets, or goes to IDLE.
  - Out-of-range cancels are ignored.
- **Undefined:** no cancel ports; pending bits clear only on service.

## Structure
- Package `elevator_pkg`:
  - `FLOOR_W`=5, `MAX_FLOORS`=15;
  - state enum `disp_state_t` {IDLE, UP, DOWN, DWELL};
  - `floor_t` typedef.
- One sub-module `floor_prio_enc`: parameterised, returns the nearest set bit above or below a given floor plus a found flag. It is instantiated twice (above, below).

## Test plan
- Reset, `cur_floor`=0, call floor 5 → `pending`=0x0020 next cycle; then UP with `requested_floor`=5; car modelled to 5 with `at_floor` → `dwell`=1 for 4 cycles, `pending`=0, then IDLE.
- Car at 2 going UP to 9; call floor 6 → `requested_floor` becomes 6 next cycle; after dwell it goes back to 9.
- Car at 7 in UP, calls 3 and 12 pending → serves 12 first; after dwell, `dir_up`=0 and `requested_floor`=3.
- `call_floor`=15 and 31 → `pending` unchanged, `busy`=0.
- Call to `cur_floor` during DWELL → absorbed, `pending` bit stays 0.
- Reset asserted mid-UP with 3 pending → immediately `pending`=0, `requested_floor`=0, `busy`=0.
- With `DISPATCH_CANCEL_EN`: cancel the active target 9 while at 4 → IDLE next cycle, `requested_floor`=4.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types and limits for the elevator dispatcher and its priority encoders.
package elevator_pkg;

    localparam int FLOOR_W    = 5;
    localparam int MAX_FLOORS = 15;

    typedef logic [FLOOR_W-1:0] floor_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        UP    = 2'd1,
        DOWN  = 2'd2,
        DWELL = 2'd3
    } disp_state_t;

endpackage

// File: rtl/elevator_dispatcher_floor_prio_enc.sv
// Nearest-set-bit search in a floor mask, strictly above or strictly below a reference floor.
module floor_prio_enc
    import elevator_pkg::*;
#(
    parameter int N         = MAX_FLOORS,
    parameter bit SEARCH_UP = 1'b1
) (
    input  logic [N-1:0] mask,
    input  floor_t       floor,
    output logic         found,
    output floor_t       sel
);

    logic hit_s;

    // Later matches overwrite earlier ones, so the scan order picks the nearest floor.
    always_comb begin
        found = 1'b0;
        sel   = {FLOOR_W{1'b0}};
        hit_s = 1'b0;
        if (SEARCH_UP) begin
            for (int i = N - 1; i >= 0; i--) begin
                hit_s = mask[i] && (floor_t'(i) > floor);
                found = found | hit_s;
                sel   = hit_s ? floor_t'(i) : sel;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                hit_s = mask[i] && (floor_t'(i) < floor);
                found = found | hit_s;
                sel   = hit_s ? floor_t'(i) : sel;
            end
        end
    end

endmodule

// File: rtl/elevator_dispatcher.sv
// SCAN-order request dispatcher in front of the elevator controller.
// Optional DISPATCH_CANCEL_EN adds a call-cancel port pair.
module elevator_dispatcher
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS   = 15,
    parameter int DWELL_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  call_valid,
    input  logic [4:0]            call_floor,
`ifdef DISPATCH_CANCEL_EN
    input  logic                  cancel_valid,
    input  logic [4:0]            cancel_floor,
`endif
    input  logic [4:0]            cur_floor,
    input  logic                  at_floor,
    output logic [4:0]            requested_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dir_up,
    output logic                  dwell,
    output logic                  busy
);

    localparam floor_t                  NUM_F      = floor_t'(NUM_FLOORS);
    localparam logic [7:0]              DWELL_LOAD = 8'(DWELL_CYCLES - 1);
    localparam logic [NUM_FLOORS-1:0]   ZERO_MASK  = {NUM_FLOORS{1'b0}};
    localparam logic [NUM_FLOORS-1:0]   ONE_MASK   = {{(NUM_FLOORS-1){1'b0}}, 1'b1};

    disp_state_t           state_r;
    floor_t                requested_floor_r;
    logic [NUM_FLOORS-1:0] pending_r;
    logic                  dir_up_r, dwell_r, busy_r;
    logic [7:0]            cnt_r;

    logic [NUM_FLOORS-1:0] call_mask_s, clear_mask_s, cancel_mask_s, pend_eff_s;
    logic                  arrive_s, cur_pend_s;
    logic                  up_found_s, dn_found_s;
    floor_t                up_sel_s, dn_sel_s;

    function automatic logic [NUM_FLOORS-1:0] onehot(input floor_t f);
        return (f < NUM_F) ? (ONE_MASK << f) : ZERO_MASK;
    endfunction

    function automatic logic bit_of(input logic [NUM_FLOORS-1:0] m, input floor_t f);
        logic [NUM_FLOORS-1:0] t;
        t = m >> f;
        return (f < NUM_F) && t[0];
    endfunction

    assign call_mask_s = call_valid ? onehot(call_floor) : ZERO_MASK;
`ifdef DISPATCH_CANCEL_EN
    assign cancel_mask_s = cancel_valid ? onehot(cancel_floor) : ZERO_MASK;
`else
    assign cancel_mask_s = ZERO_MASK;
`endif
    // A same-cycle cancel is visible to the encoders so a cancelled target is dropped at once.
    assign pend_eff_s = pending_r & ~cancel_mask_s;
    assign arrive_s   = at_floor && (cur_floor == requested_floor_r);
    assign cur_pend_s = bit_of(pend_eff_s, cur_floor);

    floor_prio_enc #(.N(NUM_FLOORS), .SEARCH_UP(1'b1)) u_enc_up (
        .mask(pend_eff_s), .floor(cur_floor), .found(up_found_s), .sel(up_sel_s)
    );
    floor_prio_enc #(.N(NUM_FLOORS), .SEARCH_UP(1'b0)) u_enc_dn (
        .mask(pend_eff_s), .floor(cur_floor), .found(dn_found_s), .sel(dn_sel_s)
    );

    // Floor whose call is served (or absorbed while the doors are open) this cycle.
    always_comb begin
        clear_mask_s = ZERO_MASK;
        case (state_r)
            IDLE:     clear_mask_s = cur_pend_s ? onehot(cur_floor) : ZERO_MASK;
            UP, DOWN: clear_mask_s = arrive_s ? onehot(requested_floor_r) : ZERO_MASK;
            DWELL:    clear_mask_s = onehot(cur_floor);
            default:  clear_mask_s = ZERO_MASK;
        endcase
    end

    // Pending-call mask: clears and cancels beat same-cycle calls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_r <= ZERO_MASK;
        end else begin
            pending_r <= (pending_r | call_mask_s) & ~clear_mask_s & ~cancel_mask_s;
        end
    end

    // Dispatch FSM with registered target, direction and status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r           <= IDLE;
            requested_floor_r <= 5'd0;
            dir_up_r          <= 1'b1;
            dwell_r           <= 1'b0;
            busy_r            <= 1'b0;
            cnt_r             <= 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    requested_floor_r <= cur_floor;
                    if (cur_pend_s) begin
                        state_r <= DWELL; dwell_r <= 1'b1; busy_r <= 1'b1; cnt_r <= DWELL_LOAD;
                    end else if (up_found_s && (dir_up_r || !dn_found_s)) begin
                        state_r <= UP; dir_up_r <= 1'b1; busy_r <= 1'b1; requested_floor_r <= up_sel_s;
                    end else if (dn_found_s) begin
                        state_r <= DOWN; dir_up_r <= 1'b0; busy_r <= 1'b1; requested_floor_r <= dn_sel_s;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                UP, DOWN: begin
                    if (arrive_s) begin
                        state_r <= DWELL; dwell_r <= 1'b1; cnt_r <= DWELL_LOAD;
                        requested_floor_r <= cur_floor;
                    end else if ((state_r == UP) && up_found_s) begin
                        requested_floor_r <= up_sel_s;
                    end else if ((state_r == DOWN) && dn_found_s) begin
                        requested_floor_r <= dn_sel_s;
                    end else begin
                        state_r <= IDLE; busy_r <= 1'b0; requested_floor_r <= cur_floor;
                    end
                end
                DWELL: begin
                    requested_floor_r <= cur_floor;
                    if (cnt_r != 8'd0) begin
                        cnt_r <= cnt_r - 8'd1;
                    end else if ((dir_up_r || !dn_found_s) && up_found_s) begin
                        state_r <= UP; dir_up_r <= 1'b1; dwell_r <= 1'b0; requested_floor_r <= up_sel_s;
                    end else if (dn_found_s) begin
                        state_r <= DOWN; dir_up_r <= 1'b0; dwell_r <= 1'b0; requested_floor_r <= dn_sel_s;
                    end else begin
                        state_r <= IDLE; dwell_r <= 1'b0; busy_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE; dwell_r <= 1'b0; busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign requested_floor = requested_floor_r;
    assign pending         = pending_r;
    assign dir_up          = dir_up_r;
    assign dwell           = dwell_r;
    assign busy            = busy_r;

endmodule
